// File: rtl/user_codes_pkg.sv
// Shared code map, FSM state encoding and helpers for the user selector.
package user_codes_pkg;

  localparam logic [2:0] CODE_NEUTRAL   = 3'b000;
  localparam logic [2:0] CODE_USER      = 3'b001;
  localparam logic [2:0] CODE_INVALID   = 3'b010;
  localparam logic [2:0] CODE_TESTER    = 3'b011;
  localparam logic [2:0] CODE_INV_REQ   = 3'b100;
  localparam logic [2:0] CODE_ADMIN     = 3'b101;
  localparam logic [2:0] CODE_GUEST     = 3'b110;
  localparam logic [2:0] CODE_AUTOPILOT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_SHOW_INVALID = 2'd1,
    ST_LOGGED       = 2'd2
  } state_t;

  // True for codes that open (or replace) a session.
  function automatic logic is_valid_user(input logic [2:0] code);
    case (code)
      CODE_USER, CODE_TESTER, CODE_ADMIN, CODE_GUEST, CODE_AUTOPILOT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Counter width for a count of n; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debouncer.sv
// Two-flop synchronizer, stability down-counter and rising-edge pulse for one
// raw button. After reset the button must first be seen stably released before
// any press can pulse, so a button held through reset stays silent.
module debouncer
  import user_codes_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [1:0]       r_fill;
  logic             r_armed;
  logic             r_level;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;
  logic             w_real;
  logic             w_change;

  // r_sync2 only carries real button data once both sync flops have refilled.
  assign w_real   = r_fill[1];
  // Before arming, the target is a stable release; afterwards, any level change.
  assign w_change = w_real && (r_armed ? (r_sync2 != r_level) : !r_sync2);
  assign o_pulse  = r_pulse;

  // Synchronize the raw button and track refill after reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_fill  <= 2'b00;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_fill  <= {r_fill[0], 1'b1};
    end
  end

  // Accept a level after DEBOUNCE_CYCLES consecutive agreeing samples; pulse on 0->1.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_armed <= 1'b0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (!w_change) begin
        r_cnt <= CNT_LOAD;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end else begin
        r_cnt <= CNT_LOAD;
        if (r_armed) begin
          r_level <= r_sync2;
          r_pulse <= r_sync2;
        end else begin
          r_armed <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/user_selector.sv
// User login selector: debounced Confirm/Logout buttons drive a small session
// FSM whose registered outputs feed the display decoder.
//
// state           | meaning
// ST_IDLE         | no session, User = 000
// ST_SHOW_INVALID | invalid request shown as 010 for INVALID_HOLD cycles
// ST_LOGGED       | session open, User = latched code, Logged = 1
module user_selector
  import user_codes_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int INVALID_HOLD    = 8,
  parameter int SESSION_CYCLES  = 32
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [2:0] Switches,
  input  logic       Confirm,
  input  logic       Logout,
  output logic [2:0] User,
  output logic       Logged
);

  localparam int INV_W  = cnt_width(INVALID_HOLD);
  localparam int SESS_W = cnt_width(SESSION_CYCLES);
  localparam logic [INV_W-1:0]  INV_LOAD  = INV_W'(INVALID_HOLD - 1);
  localparam logic [SESS_W-1:0] SESS_LOAD = SESS_W'(SESSION_CYCLES - 1);

  state_t              r_state;
  logic [2:0]          r_user;
  logic                r_logged;
  logic [INV_W-1:0]    r_inv_cnt;
  logic [SESS_W-1:0]   r_sess_cnt;
  logic                w_confirm;
  logic                w_logout;
  logic                w_sw_valid;

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_confirm (
    .i_clk   (Clock),
    .i_rst_n (Reset_n),
    .i_btn   (Confirm),
    .o_pulse (w_confirm)
  );

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_logout (
    .i_clk   (Clock),
    .i_rst_n (Reset_n),
    .i_btn   (Logout),
    .o_pulse (w_logout)
  );

  assign w_sw_valid = is_valid_user(Switches);
  assign User       = r_user;
  assign Logged     = r_logged;

  // Session FSM; outputs are registered alongside the state. Logout has priority.
  always_ff @(posedge Clock) begin
    if (!Reset_n || w_logout) begin
      r_state    <= ST_IDLE;
      r_user     <= CODE_NEUTRAL;
      r_logged   <= 1'b0;
      r_inv_cnt  <= '0;
      r_sess_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_confirm) begin
            if (w_sw_valid) begin
              r_state    <= ST_LOGGED;
              r_user     <= Switches;
              r_logged   <= 1'b1;
              r_sess_cnt <= SESS_LOAD;
            end else if (Switches != CODE_NEUTRAL) begin
              r_state   <= ST_SHOW_INVALID;
              r_user    <= CODE_INVALID;
              r_inv_cnt <= INV_LOAD;
            end
          end
        end
        ST_SHOW_INVALID: begin
          if (r_inv_cnt == '0) begin
            r_state <= ST_IDLE;
            r_user  <= CODE_NEUTRAL;
          end else begin
            r_inv_cnt <= r_inv_cnt - INV_W'(1);
          end
        end
        ST_LOGGED: begin
          if (w_confirm && w_sw_valid) begin
            r_user     <= Switches;
            r_sess_cnt <= SESS_LOAD;
          end else if (r_user == CODE_AUTOPILOT) begin
            r_sess_cnt <= r_sess_cnt;
          end else if (r_sess_cnt == '0) begin
            r_state  <= ST_IDLE;
            r_user   <= CODE_NEUTRAL;
            r_logged <= 1'b0;
          end else begin
            r_sess_cnt <= r_sess_cnt - SESS_W'(1);
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_user   <= CODE_NEUTRAL;
          r_logged <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_user_selector.sv
// Directed bench for user_selector with default parameters.
module tb_user_selector;

  logic       Clock;
  logic       Reset_n;
  logic [2:0] Switches;
  logic       Confirm;
  logic       Logout;
  logic [2:0] User;
  logic       Logged;

  int checks = 0;
  int errors = 0;
  int n_conf_pulse = 0;
  int n_user_chg = 0;
  logic [2:0] prev_user = 3'b000;

  user_selector dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Switches (Switches),
    .Confirm  (Confirm),
    .Logout   (Logout),
    .User     (User),
    .Logged   (Logged)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (dut.u_db_confirm.o_pulse === 1'b1) n_conf_pulse++;
    if (User !== prev_user) n_user_chg++;
    prev_user = User;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic do_logout();
    Logout = 1'b1;
    tick(8);
    Logout = 1'b0;
    tick(8);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    tick(3);
    checks++; if (User !== 3'b000) begin errors++; $display("FAIL reset_user got %b exp 000", User); end
    checks++; if (Logged !== 1'b0) begin errors++; $display("FAIL reset_logged got %b exp 0", Logged); end
    Reset_n = 1'b1;
    tick(10);
    checks++; if (User !== 3'b000) begin errors++; $display("FAIL idle_user got %b exp 000", User); end
  endtask

  task automatic test_login();
    Switches = 3'b101;
    n_user_chg = 0;
    Confirm = 1'b1;
    tick(6);
    checks++; if (User !== 3'b000) begin errors++; $display("FAIL login_early got %b exp 000", User); end
    tick(1);
    checks++; if (User !== 3'b101) begin errors++; $display("FAIL login_user got %b exp 101", User); end
    checks++; if (Logged !== 1'b1) begin errors++; $display("FAIL login_logged got %b exp 1", Logged); end
    tick(3);
    Confirm = 1'b0;
    tick(10);
    checks++; if (User !== 3'b101) begin errors++; $display("FAIL login_hold got %b exp 101", User); end
    checks++; if (n_user_chg !== 1) begin errors++; $display("FAIL login_transitions got %0d exp 1", n_user_chg); end
    do_logout();
    checks++; if (User !== 3'b000) begin errors++; $display("FAIL logout_user got %b exp 000", User); end
  endtask

  task automatic test_bounce();
    Switches = 3'b001;
    n_conf_pulse = 0;
    Confirm = 1'b1; tick(1);
    Confirm = 1'b0; tick(1);
    Confirm = 1'b1; tick(1);
    Confirm = 1'b0; tick(1);
    Confirm = 1'b1;
    tick(6);
    checks++; if (User !== 3'b000) begin errors++; $display("FAIL bounce_early got %b exp 000", User); end
    tick(1);
    checks++; if (User !== 3'b001) begin errors++; $display("FAIL bounce_user got %b exp 001", User); end
    tick(10);
    Confirm = 1'b0;
    tick(8);
    checks++; if (n_conf_pulse !== 1) begin errors++; $display("FAIL bounce_pulses got %0d exp 1", n_conf_pulse); end
    do_logout();
  endtask

  task automatic test_reload();
    Switches = 3'b001;
    Confirm = 1'b1;
    tick(7);
    checks++; if (User !== 3'b001) begin errors++; $display("FAIL reload_login got %b exp 001", User); end
    tick(1);
    Confirm = 1'b0;
    tick(8);
    Switches = 3'b010;
    Confirm = 1'b1;
    tick(7);
    checks++; if (User !== 3'b001) begin errors++; $display("FAIL logged_invalid_ignored got %b exp 001", User); end
    Confirm = 1'b0;
    tick(7);
    Switches = 3'b110;
    Confirm = 1'b1;
    tick(7);
    checks++; if (User !== 3'b110) begin errors++; $display("FAIL relogin_user got %b exp 110", User); end
    Confirm = 1'b0;
    tick(31);
    checks++; if (User !== 3'b110) begin errors++; $display("FAIL reload_alive got %b exp 110", User); end
    tick(1);
    checks++; if (User !== 3'b000) begin errors++; $display("FAIL reload_timeout got %b exp 000", User); end
  endtask

  task automatic test_timeout();
    Switches = 3'b001;
    Confirm = 1'b1;
    tick(7);
    checks++; if (User !== 3'b001) begin errors++; $display("FAIL timeout_login got %b exp 001", User); end
    tick(3);
    Confirm = 1'b0;
    tick(28);
    checks++; if (User !== 3'b001) begin errors++; $display("FAIL timeout_alive got %b exp 001", User); end
    checks++; if (Logged !== 1'b1) begin errors++; $display("FAIL timeout_alive_logged got %b exp 1", Logged); end
    tick(1);
    checks++; if (User !== 3'b000) begin errors++; $display("FAIL timeout_user got %b exp 000", User); end
    checks++; if (Logged !== 1'b0) begin errors++; $display("FAIL timeout_logged got %b exp 0", Logged); end
  endtask

  task automatic test_autopilot();
    Switches = 3'b111;
    Confirm = 1'b1;
    tick(7);
    checks++; if (User !== 3'b111) begin errors++; $display("FAIL autopilot_login got %b exp 111", User); end
    tick(3);
    Confirm = 1'b0;
    tick(97);
    checks++; if (User !== 3'b111) begin errors++; $display("FAIL autopilot_hold got %b exp 111", User); end
    checks++; if (Logged !== 1'b1) begin errors++; $display("FAIL autopilot_logged got %b exp 1", Logged); end
    do_logout();
  endtask

  task automatic test_invalid();
    Switches = 3'b100;
    n_conf_pulse = 0;
    Confirm = 1'b1;
    tick(4);
    Confirm = 1'b0;
    tick(2);
    checks++; if (User !== 3'b000) begin errors++; $display("FAIL invalid_early got %b exp 000", User); end
    tick(1);
    checks++; if (User !== 3'b010) begin errors++; $display("FAIL invalid_show got %b exp 010", User); end
    tick(1);
    Switches = 3'b001;
    Confirm = 1'b1;
    tick(6);
    checks++; if (User !== 3'b010) begin errors++; $display("FAIL invalid_last got %b exp 010", User); end
    tick(1);
    checks++; if (User !== 3'b000) begin errors++; $display("FAIL invalid_end got %b exp 000", User); end
    checks++; if (Logged !== 1'b0) begin errors++; $display("FAIL invalid_logged got %b exp 0", Logged); end
    tick(4);
    Confirm = 1'b0;
    tick(8);
    checks++; if (User !== 3'b000) begin errors++; $display("FAIL invalid_after got %b exp 000", User); end
    checks++; if (n_conf_pulse !== 2) begin errors++; $display("FAIL invalid_pulses got %0d exp 2", n_conf_pulse); end
  endtask

  task automatic test_logout_wins();
    Switches = 3'b011;
    Confirm = 1'b1;
    tick(7);
    checks++; if (User !== 3'b011) begin errors++; $display("FAIL tester_login got %b exp 011", User); end
    tick(1);
    Confirm = 1'b0;
    tick(8);
    Switches = 3'b110;
    Confirm = 1'b1;
    Logout = 1'b1;
    tick(6);
    checks++; if (User !== 3'b011) begin errors++; $display("FAIL both_early got %b exp 011", User); end
    tick(1);
    checks++; if (User !== 3'b000) begin errors++; $display("FAIL both_user got %b exp 000", User); end
    checks++; if (Logged !== 1'b0) begin errors++; $display("FAIL both_logged got %b exp 0", Logged); end
    tick(3);
    Confirm = 1'b0;
    Logout = 1'b0;
    tick(8);
    checks++; if (User !== 3'b000) begin errors++; $display("FAIL both_after got %b exp 000", User); end
  endtask

  task automatic test_reset_held();
    Switches = 3'b001;
    Confirm = 1'b1;
    tick(7);
    checks++; if (User !== 3'b001) begin errors++; $display("FAIL held_login got %b exp 001", User); end
    tick(2);
    Reset_n = 1'b0;
    tick(1);
    Reset_n = 1'b1;
    checks++; if (User !== 3'b000) begin errors++; $display("FAIL held_reset_user got %b exp 000", User); end
    checks++; if (Logged !== 1'b0) begin errors++; $display("FAIL held_reset_logged got %b exp 0", Logged); end
    Switches = 3'b101;
    tick(20);
    checks++; if (User !== 3'b000) begin errors++; $display("FAIL held_no_login got %b exp 000", User); end
    Confirm = 1'b0;
    tick(8);
    Confirm = 1'b1;
    tick(6);
    checks++; if (User !== 3'b000) begin errors++; $display("FAIL repress_early got %b exp 000", User); end
    tick(1);
    checks++; if (User !== 3'b101) begin errors++; $display("FAIL repress_login got %b exp 101", User); end
    Confirm = 1'b0;
    tick(4);
  endtask

  initial begin
    Reset_n  = 1'b0;
    Switches = 3'b000;
    Confirm  = 1'b0;
    Logout   = 1'b0;
    test_reset();
    test_login();
    test_bounce();
    test_reload();
    test_timeout();
    test_autopilot();
    test_invalid();
    test_logout_wins();
    test_reset_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
